ddp_pkt_cut: RTL

- Consumer side of the DDP packet loop FIFO (8-deep, 267-bit, first-word-fall-through).
- Pops 256-bit packet words and cuts each word into narrower lane beats on a valid/ready stream toward the DMA engine.
- Regenerates sop/eop/keep per beat and flags malformed framing.

---
 rtl/ddp_pkg.sv | 19 +
 rtl/ddp_lane_keep.sv | 28 ++
 rtl/ddp_pkt_cut.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ddp_pkg.sv
// ddp_pkg: shared DDP packet word layout, framing state and byte-count helper.
//   Word layout: [266] sop, [265] eop, [264:256] byteCnt, [255:0] payload (byte 0 = [7:0]).
package ddp_pkg;
    localparam int DDP_SOP_BIT   = 266;
    localparam int DDP_EOP_BIT   = 265;
    localparam int DDP_CNT_HI    = 264;
    localparam int DDP_CNT_LO    = 256;
    localparam int DDP_DATA_W    = 256;
    localparam int DDP_WORD_W    = 267;
    localparam int DDP_MAX_BYTES = 32;

    typedef logic [DDP_WORD_W-1:0] ddp_word_t;

    typedef enum logic {DDP_IDLE = 1'b0, DDP_INPKT = 1'b1} ddp_frm_e;

    function automatic logic ddp_cnt_bad(input logic [8:0] cnt);
        return cnt == 9'd0 || cnt > 9'(DDP_MAX_BYTES);
    endfunction
endpackage

// File: rtl/ddp_lane_keep.sv
// ddp_lane_keep: beat byte-enable and last-lane decode for one hold word.
//   byte_cnt_i  valid bytes of an eop word (already sanitised to 1..32)
//   lane_idx_i  current lane index
//   eop_i       hold word is the packet's eop word
//   keep_o      contiguous byte enables for this lane
//   last_lane_o this lane is the word's final beat
module ddp_lane_keep #(
    parameter int LANE_W = 64,
    parameter int LIW    = $clog2(256 / LANE_W)
) (
    input  logic [8:0]          byte_cnt_i,
    input  logic [LIW-1:0]      lane_idx_i,
    input  logic                eop_i,
    output logic [LANE_W/8-1:0] keep_o,
    output logic                last_lane_o
);
    localparam int LB    = LANE_W / 8;
    localparam int NLANE = 256 / LANE_W;

    logic [9:0] cnt_ext, lanes, rem;

    assign cnt_ext     = {1'b0, byte_cnt_i};
    assign lanes       = eop_i ? (cnt_ext + 10'(LB - 1)) / 10'(LB) : 10'(NLANE);
    assign last_lane_o = 10'(lane_idx_i) == lanes - 10'd1;
    // Bytes remaining from this lane's start; a partial lane keeps only its low rem bytes.
    assign rem         = cnt_ext - 10'(lane_idx_i) * 10'(LB);
    assign keep_o      = (eop_i && last_lane_o && rem < 10'(LB)) ? ~({LB{1'b1}} << rem) : '1;
endmodule

// File: rtl/ddp_pkt_cut.sv
// ddp_pkt_cut: pops 256-bit DDP FIFO words and cuts them into LANE_W beats with sop/eop/keep.
//   clock, reset (sync, active-low)
//   ddpPktDataIn/ddpPktEmpty/ddpPktPop : FWFT FIFO head interface
//   outData/outKeep/outSop/outEop/outValid/outReady : beat stream to DMA
//   errBadCnt/errSeq : sticky framing errors, errClr clears them
//   Optional DDP_CUT_STAT_EN adds statPkts/statBeats counters.
module ddp_pkt_cut
    import ddp_pkg::*;
#(
    parameter int LANE_W = 64
`ifdef DDP_CUT_STAT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DDP_WORD_W-1:0] ddpPktDataIn,
    input  logic                  ddpPktEmpty,
    output logic                  ddpPktPop,
    output logic [LANE_W-1:0]     outData,
    output logic [LANE_W/8-1:0]   outKeep,
    output logic                  outSop,
    output logic                  outEop,
    output logic                  outValid,
    input  logic                  outReady,
    output logic                  errBadCnt,
    output logic                  errSeq,
`ifdef DDP_CUT_STAT_EN
    output logic [CNT_W-1:0]      statPkts,
    output logic [CNT_W-1:0]      statBeats,
`endif
    input  logic                  errClr
);
    localparam int NLANE = 256 / LANE_W;
    localparam int LIW   = $clog2(NLANE);

    ddp_word_t hold_q, hold_d, in_fix;
    ddp_frm_e frm_q, frm_d, frm_cur;
    logic [LIW-1:0] lane_q, lane_d;
    logic full_q, full_d, err_bad_q, err_bad_d, err_seq_q, err_seq_d;
    logic sop_in, eop_in, bad_cnt, accept, last_lane, last_acc, pop;
    logic [LANE_W/8-1:0] keep;
    logic [DDP_DATA_W-1:0] payload;

    assign sop_in  = ddpPktDataIn[DDP_SOP_BIT];
    assign eop_in  = ddpPktDataIn[DDP_EOP_BIT];
    assign bad_cnt = eop_in && ddp_cnt_bad(ddpPktDataIn[DDP_CNT_HI:DDP_CNT_LO]);
    // Illegal counts are stored as a full word so downstream beats stay well formed.
    assign in_fix  = {sop_in, eop_in,
                      bad_cnt ? 9'(DDP_MAX_BYTES) : ddpPktDataIn[DDP_CNT_HI:DDP_CNT_LO],
                      ddpPktDataIn[DDP_DATA_W-1:0]};

    assign accept   = full_q && outReady;
    assign last_acc = accept && last_lane;
    // Reloading on the last accepted beat keeps a continuous stream bubble-free.
    assign pop      = reset && !ddpPktEmpty && (!full_q || last_acc);

    ddp_lane_keep #(.LANE_W(LANE_W), .LIW(LIW)) u_keep (
        .byte_cnt_i  (hold_q[DDP_CNT_HI:DDP_CNT_LO]),
        .lane_idx_i  (lane_q),
        .eop_i       (hold_q[DDP_EOP_BIT]),
        .keep_o      (keep),
        .last_lane_o (last_lane)
    );

    always_comb begin
        // Framing of the incoming word is judged against the state after the current word completes.
        frm_cur   = (last_acc && hold_q[DDP_EOP_BIT]) ? DDP_IDLE : frm_q;
        frm_d     = pop ? DDP_INPKT : frm_cur;
        hold_d    = pop ? in_fix : hold_q;
        full_d    = pop || (full_q && !last_acc);
        lane_d    = (pop || last_acc) ? '0 : accept ? lane_q + LIW'(1) : lane_q;
        err_bad_d = (err_bad_q && !errClr) || (pop && bad_cnt);
        err_seq_d = (err_seq_q && !errClr) || (pop && (sop_in == (frm_cur == DDP_INPKT)));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_q    <= '0;
            frm_q     <= DDP_IDLE;
            lane_q    <= '0;
            full_q    <= 1'b0;
            err_bad_q <= 1'b0;
            err_seq_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            frm_q     <= frm_d;
            lane_q    <= lane_d;
            full_q    <= full_d;
            err_bad_q <= err_bad_d;
            err_seq_q <= err_seq_d;
        end
    end

    assign payload   = hold_q[DDP_DATA_W-1:0];
    assign ddpPktPop = pop;
    assign outValid  = full_q;
    assign outData   = full_q ? payload[lane_q * LANE_W +: LANE_W] : '0;
    assign outKeep   = full_q ? keep : '0;
    assign outSop    = full_q && hold_q[DDP_SOP_BIT] && lane_q == '0;
    assign outEop    = full_q && hold_q[DDP_EOP_BIT] && last_lane;
    assign errBadCnt = err_bad_q;
    assign errSeq    = err_seq_q;

`ifdef DDP_CUT_STAT_EN
    logic [CNT_W-1:0] pkts_q, pkts_d, beats_q, beats_d;

    always_comb begin
        pkts_d  = pkts_q + CNT_W'(accept && outEop);
        beats_d = beats_q + CNT_W'(accept);
    end

    always_ff @(posedge clock) begin
        if (!reset || errClr) begin
            pkts_q  <= '0;
            beats_q <= '0;
        end else begin
            pkts_q  <= pkts_d;
            beats_q <= beats_d;
        end
    end

    assign statPkts  = pkts_q;
    assign statBeats = beats_q;
`endif
endmodule
